// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the accumulator CPU.
package acc_cpu_pkg;

    localparam int DEF_DW = 4;
    localparam int DEF_AW = 4;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_LDI   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/acc_cpu_param_fsm_if.sv
// Instruction handshake and result bus between the pin wrapper and the accumulator CPU.
interface acc_cpu_param_fsm_if import acc_cpu_pkg::*; #(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] acc_out;
    logic          carry;
    logic          zero;
    logic          result_valid;

    modport master (
        output instr_valid, opcode, addr, data_in,
        input  instr_ready, acc_out, carry, zero, result_valid
    );

    modport slave (
        input  instr_valid, opcode, addr, data_in,
        output instr_ready, acc_out, carry, zero, result_valid
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: result, carry and write enables for one accumulator instruction.
// Latency: 0 cycles (pure logic). Backpressure: none; the caller decides when to commit.
// Optional ACC_CPU_SATURATE_EN clamps ADD/ADDM to all-ones and SUB to zero; carry still flags it.
module acc_cpu_alu import acc_cpu_pkg::*; #(
    parameter int DW = DEF_DW
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] operand,
    input  logic [DW-1:0] mem_word,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          wr_acc,
    output logic          wr_mem,
    output logic          upd_flags
);
    logic [DW-1:0] addend;
    logic [DW:0]   sum_w;
    logic [DW:0]   dif_w;

    assign addend = (opcode == OP_ADDM) ? mem_word : operand;
    assign sum_w  = {1'b0, acc} + {1'b0, addend};
    // MSB of the widened difference is the borrow, i.e. acc < operand
    assign dif_w  = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        result = acc;
        carry  = 1'b0;
        wr_acc = 1'b1;
        wr_mem = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDM: begin
                result = sum_w[DW-1:0];
                carry  = sum_w[DW];
`ifdef ACC_CPU_SATURATE_EN
                if (sum_w[DW]) result = '1;
`endif
            end
            OP_SUB: begin
                result = dif_w[DW-1:0];
                carry  = dif_w[DW];
`ifdef ACC_CPU_SATURATE_EN
                if (dif_w[DW]) result = '0;
`endif
            end
            OP_STORE: begin
                wr_acc = 1'b0;
                wr_mem = 1'b1;
            end
            OP_LOAD: result = mem_word;
            OP_LDI:  result = operand;
            OP_AND:  result = acc & operand;
            OP_OR:   result = acc | operand;
            OP_XOR:  result = acc ^ operand;
            OP_NOT:  result = ~acc;
            OP_SHL: begin
                result = {acc[DW-2:0], 1'b0};
                carry  = acc[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[DW-1:1]};
                carry  = acc[0];
            end
            default: wr_acc = 1'b0;
        endcase
    end

    assign upd_flags = wr_acc;
endmodule

// File: rtl/acc_cpu_param_fsm.sv
// Parametrised accumulator CPU: IDLE/EXEC/WB FSM, register-file memory, carry/zero flags.
// Latency: accept at T0, commit at T2, result_valid strobe in the cycle after T2 (1 instr / 3 cycles).
// Backpressure: instr_ready only in IDLE with ena high; ena low freezes everything. ACC_CPU_SATURATE_EN in ALU.
module acc_cpu_param_fsm import acc_cpu_pkg::*; #(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    acc_cpu_param_fsm_if.slave bus
);
    state_t        state_q, state_d;
    logic          ready;
    logic          accept;

    logic [3:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] acc_q;
    logic          carry_q, zero_q, rv_q;
    logic [DW-1:0] mem_q [2**AW];

    logic [DW-1:0] res_q;
    logic          res_c_q, wr_acc_q, wr_mem_q, upd_q;

    logic [DW-1:0] alu_res;
    logic          alu_c, alu_wr_acc, alu_wr_mem, alu_upd;

    acc_cpu_alu #(.DW(DW)) u_alu (
        .opcode    (op_q),
        .acc       (acc_q),
        .operand   (dat_q),
        .mem_word  (mem_q[addr_q]),
        .result    (alu_res),
        .carry     (alu_c),
        .wr_acc    (alu_wr_acc),
        .wr_mem    (alu_wr_mem),
        .upd_flags (alu_upd)
    );

    assign accept = ready && bus.instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ena;
                if (accept) state_d = EXEC;
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!ena) state_d = state_q;
    end

    // EXEC registers the ALU outcome so WB commits a stable value after inputs may have moved on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            dat_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            rv_q     <= 1'b0;
            res_q    <= '0;
            res_c_q  <= 1'b0;
            wr_acc_q <= 1'b0;
            wr_mem_q <= 1'b0;
            upd_q    <= 1'b0;
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        end else if (ena) begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.opcode;
                        addr_q <= bus.addr;
                        dat_q  <= bus.data_in;
                    end
                end
                EXEC: begin
                    res_q    <= alu_res;
                    res_c_q  <= alu_c;
                    wr_acc_q <= alu_wr_acc;
                    wr_mem_q <= alu_wr_mem;
                    upd_q    <= alu_upd;
                end
                WB: begin
                    if (wr_acc_q) acc_q <= res_q;
                    if (wr_mem_q) mem_q[addr_q] <= res_q;
                    if (upd_q) begin
                        carry_q <= res_c_q;
                        zero_q  <= (res_q == '0);
                    end
                    rv_q <= 1'b1;
                end
                default: rv_q <= 1'b0;
            endcase
        end
    end

    assign bus.instr_ready  = ready;
    assign bus.acc_out      = acc_q;
    assign bus.carry        = carry_q;
    assign bus.zero         = zero_q;
    assign bus.result_valid = rv_q & ena;
endmodule

// File: tb/tb_acc_cpu_param_fsm.sv
// Randomised bench for acc_cpu_param_fsm against an instruction-level reference model.
module tb_acc_cpu_param_fsm;
    localparam int DW  = 4;
    localparam int AW  = 4;
    localparam int LIM = 1 << DW;
`ifdef ACC_CPU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    acc_cpu_param_fsm_if #(.DW(DW), .AW(AW)) bus ();

    acc_cpu_param_fsm #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int macc;
    bit mc, mz;
    int mmem [LIM];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        macc = 0; mc = 0; mz = 0;
        for (int i = 0; i < LIM; i++) mmem[i] = 0;
    endtask

    task automatic model_add(input int b);
        int s;
        s  = macc + b;
        mc = (s >= LIM);
        macc = (SAT && mc) ? LIM - 1 : s % LIM;
    endtask

    task automatic model_exec(input int op, input int a, input int d);
        case (op)
            0:  model_add(d);
            1:  begin
                    mc = (macc < d);
                    if (mc) macc = SAT ? 0 : macc - d + LIM;
                    else    macc = macc - d;
                end
            2:  mmem[a] = macc;
            3:  begin macc = mmem[a]; mc = 0; end
            4:  begin macc = d; mc = 0; end
            5:  begin macc = macc & d; mc = 0; end
            6:  begin macc = macc | d; mc = 0; end
            7:  begin macc = macc ^ d; mc = 0; end
            8:  begin macc = LIM - 1 - macc; mc = 0; end
            9:  begin mc = (macc >= LIM / 2); macc = (macc * 2) % LIM; end
            10: begin mc = macc % 2; macc = macc / 2; end
            11: model_add(mmem[a]);
            default: ;
        endcase
        if (op <= 11 && op != 2) mz = (macc == 0);
    endtask

    // mode 0: ena held high; 1: random ena every cycle; 2: ena dropped for 4 cycles in EXEC
    task automatic issue(input int op, input int a, input int d, input int mode);
        bit accepted;
        int guard, n_en, stall;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = op[3:0];
        bus.addr        = a[AW-1:0];
        bus.data_in     = d[DW-1:0];
        accepted = 1'b0;
        guard    = 0;
        while (!accepted && guard < 40) begin
            ena = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("idle_rdy", bus.instr_ready, ena);
            accepted = bus.instr_ready;
            @(negedge clk);
            guard++;
        end
        if (!accepted) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        model_exec(op, a, d);
        bus.instr_valid = 1'b0;
        bus.opcode      = 4'($urandom);
        bus.addr        = AW'($urandom);
        bus.data_in     = DW'($urandom);
        n_en  = 0;
        stall = 0;
        guard = 0;
        while (n_en < 2 && guard < 40) begin
            if (mode == 2 && n_en == 0 && stall < 4) begin
                ena = 1'b0;
                stall++;
            end else begin
                ena = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            chk("busy_rdy", bus.instr_ready, 0);
            @(posedge clk);
            #1;
            if (ena) n_en++;
            chk("rv_timing", bus.result_valid, (n_en == 2) ? 1 : 0);
            if (n_en < 2) @(negedge clk);
            guard++;
        end
        if (n_en < 2) chk("retire_timeout", 0, 1);
        chk("acc", bus.acc_out, macc);
        chk("carry", bus.carry, mc);
        chk("zero", bus.zero, mz);
        ena = 1'b1;
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.addr        = '0;
        bus.data_in     = '0;
        model_reset();
        #23;
        chk("rst_acc", bus.acc_out, 0);
        chk("rst_carry", bus.carry, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_rv", bus.result_valid, 0);
        rst_n = 1'b1;

        issue(4, 0, 5, 0);
        @(posedge clk); #1;
        chk("rv_one_cycle", bus.result_valid, 0);
        chk("ldi5_acc", bus.acc_out, 5);

        issue(4, 0, 15, 0);
        issue(0, 0, 1, 0);
        chk("add_wrap_acc", bus.acc_out, SAT ? 15 : 0);
        chk("add_wrap_carry", bus.carry, 1);

        issue(4, 0, 9, 0);
        issue(2, 3, 0, 0);
        issue(4, 0, 0, 0);
        issue(3, 3, 0, 0);
        chk("load_acc", bus.acc_out, 9);
        issue(11, 3, 0, 0);
        chk("addm_acc", bus.acc_out, SAT ? 15 : 2);

        issue(4, 0, 2, 0);
        issue(1, 0, 3, 0);
        chk("sub_borrow_acc", bus.acc_out, SAT ? 0 : 15);

        issue(4, 0, 9, 0);
        issue(9, 0, 0, 0);
        chk("shl_acc", bus.acc_out, 2);
        issue(10, 0, 0, 0);
        chk("shr_carry", bus.carry, 0);

        issue(4, 0, 6, 2);
        issue(12, 7, 3, 2);

        // reset pulse while a STORE sits in WB must leave memory untouched
        issue(4, 0, 7, 0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'h2;
        bus.addr        = 4'd5;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_acc", bus.acc_out, 0);
        chk("rst_wb_rv", bus.result_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        issue(3, 5, 0, 0);
        chk("rst_wb_mem", bus.acc_out, 0);

        for (int i = 0; i < 200; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, LIM - 1),
                  $urandom_range(0, LIM - 1), (i % 3 == 0) ? 0 : 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_cpu_param_fsm.md
Name: acc_cpu_param_fsm

Overview:
- Parametrised successor of the team's 4-bit accumulator mini-CPU.
- Generalised data width and register-file depth.
- Adds a valid/ready instruction handshake, carry/zero flags, an immediate-load and a memory-operand ALU mode, and a result-valid strobe.
- Sits behind the Tiny Tapeout pin wrapper; the wrapper maps ui_in/uio_in onto the instruction fields.

Parameters:
- DW, 4, accumulator/memory data width (2..8).
- AW, 4, memory address width; depth = 2**AW words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; low freezes FSM and all registers.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept an instruction.
- opcode  in  4  operation select.
- addr  in  AW  memory address.
- data_in  in  DW  immediate / ALU operand.
- acc_out  out  DW  accumulator contents.
- carry  out  1  carry/borrow/shift-out flag.
- zero  out  1  accumulator == 0 flag.
- result_valid  out  1  one-cycle strobe on instruction retire.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. Reset values: acc_out=0, all memory words=0, carry=0, zero=0, result_valid=0, state=IDLE.
- FSM states:
  - IDLE: instr_ready=ena. On instr_valid&&instr_ready, latch opcode/addr/data_in, go to EXEC.
  - EXEC: read mem[addr_q], compute the ALU result, go to WB.
  - WB: commit acc, memory and flags; go to IDLE.
- Handshake and timing:
  - Accept at edge T0; commit at edge T2; result_valid=1 for exactly the cycle after T2.
  - Throughput is one instruction per 3 cycles.
  - instr_ready=0 in EXEC and WB. Inputs may change after acceptance.
- Opcodes (results truncated to DW bits):
  - 0 ADD: acc+data_in.
  - 1 SUB: acc-data_in.
  - 2 STORE: mem[addr]=acc; acc unchanged.
  - 3 LOAD: acc=mem[addr].
  - 4 LDI: acc=data_in.
  - 5 AND, 6 OR, 7 XOR: acc op data_in.
  - 8 NOT: acc=~acc.
  - 9 SHL: acc<<1.
  - A SHR: acc>>1 (logical).
  - B ADDM: acc+mem[addr].
  - C..F NOP: retire normally, no state change except the result_valid strobe.
- Flags:
  - carry = DW+1-bit carry-out for ADD/ADDM; borrow (acc<data_in) for SUB; the shifted-out bit for SHL/SHR; cleared by LOAD/LDI/logic ops; unchanged by STORE/NOP.
  - zero = (new acc==0); updated on every acc-writing opcode; unchanged by STORE/NOP.
- STORE followed directly by LOAD of the same addr returns the stored value; WB commits before the next EXEC.
- ena low in any state: hold state and all registers, result_valid=0, instr_ready=0. Resume exactly where stopped.
- Reset asserted mid-instruction: abort with no memory or acc write; all outputs take reset values.
- Wrap-around: ADD overflow and SUB underflow wrap modulo 2**DW.

Optional Feature:
- ACC_CPU_SATURATE_EN.
- Defined: ADD/ADDM clamp to 2**DW-1 on carry; SUB clamps to 0 on borrow; carry still reports the overflow/borrow.
- Undefined: modular wrap as specified above.

Decomposition:
- Package acc_cpu_pkg: opcode localparams OP_ADD..OP_ADDM, FSM state encodings (IDLE/EXEC/WB, 2 bits), default DW/AW.
- Sub-module acc_cpu_alu: purely combinational. Inputs: opcode, acc, operand, mem word. Outputs: DW-bit result, carry, and write-acc/write-mem/update-flags enables. Saturation logic lives there.
- The top holds the FSM, the latches, the memory array and the flags.

Test Plan:
- Reset, then LDI 5 → acc_out=5, zero=0, carry=0; result_valid high exactly 3 cycles after accept; instr_ready low during EXEC/WB.
- DW=4: LDI 0xF, ADD 1 → acc=0, carry=1, zero=1. With ACC_CPU_SATURATE_EN: acc=0xF, carry=1.
- LDI 9, STORE addr 3, LDI 0, LOAD addr 3 → acc=9; ADDM addr 3 → acc=2 (wrapped), carry=1.
- LDI 2, SUB 3 → acc=0xF, carry=1 (borrow). With ACC_CPU_SATURATE_EN: acc=0, carry=1.
- LDI 0x9: SHL → acc=0x2, carry=1; then SHR → acc=0x1, carry=0.
- Drop ena in EXEC for 4 cycles → no progress and result_valid stays 0, then completes on resume. Pulse rst_n low during WB of STORE → memory word remains 0.
